multi_phase_clk_div: RTL
========================

# multi_phase_clk_div

Parametrised multi-channel clock divider from the 50 MHz system clock. Each of NCH channels produces a square-wave output with a programmable half-period and a programmable start delay (phase offset). It also emits a one-cycle tick on every output toggle. It replaces single-channel fixed-ratio dividers in the modulator datapath and provides the phase-aligned symbol/carrier clocks the 2ASK and QPSK paths need (e.g. I/Q offset).

## Interface
- NCH, 4, number of channels (≥1)
- CW, 30, counter/config width
- DEF_HALF, 500, reset half-period in clk50m cycles (50 kHz output)
- clk50m  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  NCH  per-channel enable
- sync  in  1  global phase-realign pulse
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accept, combinational on cfg_ch
- cfg_ch  in  $clog2(NCH) (min 1)  target channel
- cfg_half  in  CW  half-period; 0 is treated as 1
- cfg_delay  in  CW  start delay in cycles
- clk_out  out  NCH  divided clocks, registered
- tick  out  NCH  one-cycle pulse coincident with each clk_out toggle
- running  out  NCH  1 when channel state is not IDLE

## Operation
- Per-channel state, active half, active delay, shadow half, pending flag, counter cnt of CW bits.
- States are IDLE, DELAY and RUN.
- Reset values: clk_out=0, tick=0, running=0, state=IDLE, half=DEF_HALF, delay=0, pending=0, cnt=0.
- IDLE with en=1 sampled: if delay==0, go to RUN; else go to DELAY. In both cases cnt<=0 and clk_out stays 0.
- DELAY: cnt increments. At the edge where cnt==delay-1, go to RUN and set cnt<=0. DELAY therefore lasts exactly delay cycles.
- RUN: cnt increments. At the edge where cnt==half-1:
  - clk_out toggles and tick=1 for that cycle;
  - cnt<=0;
  - if pending, half<=shadow and pending<=0.
- en=0 sampled in any state: go to IDLE next edge, with clk_out<=0, cnt<=0 and tick=0. A pending half is applied immediately.
- sync=1 sampled:
  - every channel not IDLE and with en=1 restarts, going to DELAY (or RUN if delay==0);
  - cnt<=0, clk_out<=0, pending half applied, tick=0;
  - IDLE channels ignore sync.
- Priority per channel, highest first: rst, en=0, sync, start/terminal-count.
- Config write is accepted when cfg_valid&&cfg_ready.
  - cfg_ready = !pending[cfg_ch].
  - Target IDLE and not starting this edge: half and delay load directly.
  - Otherwise (DELAY/RUN, or starting on the same edge): delay loads directly and takes effect at the next start. Half goes to shadow with pending<=1.
- A write accepted on the same edge as a tick becomes pending and is applied at the following tick.
- A half change never truncates a period in progress; it only takes effect at a period boundary.
- cfg_ch ≥ NCH: cfg_ready=1, and the write is accepted and discarded.

## Timing
- en sampled high at edge k from IDLE: first clk_out rise is registered at edge k+delay+half. Subsequent toggles follow every half edges, giving period 2·half.
- sync at edge s: clk_out low from edge s. First rise at s+delay+half.
- Disable latency is 1 edge, for both clk_out=0 and running=0.
- cfg_ready drops the cycle after a pending write is accepted. It rises the cycle after the applying tick/sync/disable.
- Maximum half and delay are 2^CW-1. The counter never exceeds half-1 or delay-1, so it does not wrap.

## Structure
- Shared package holds:
  - state typedef (IDLE, DELAY, RUN);
  - DEF_HALF default;
  - function mapping half 0→1.
- Sub-module clk_div_channel holds one channel's FSM, counter, active/shadow registers and pending flag. It is instantiated NCH times via generate.
- Top level holds cfg decode, the cfg_ready mux and sync fan-out.

## Test plan
- Reset, all en=1 at edge 0, default config → every clk_out rises at edge 500 and falls at 1000. tick pulses at 500, 1000; running=1 from edge 1.
- ch1 idle write half=4, delay=3, en[1] rises at edge 0 → clk_out[1] rises at edge 7, falls at 11, rises at 15.
- ch0 running with half=4, write half=2 mid-period → cfg_ready(ch0)=0 until the next tick. The current half-period completes at 4 and later toggles come every 2. cfg_ready returns 1 the cycle after the tick.
- Channels with half=5 and delays 0,1,2,3, sync pulse at edge 100 → all clk_out=0 from edge 100, with rises at edges 105, 106, 107 and 108.
- en[2]=0 mid-period → clk_out[2]=0 and running[2]=0 at the next edge. Re-enable restarts the full delay+half sequence.
- cfg_half=0 written to idle ch3 then enabled with delay 0 → clk_out[3] toggles every cycle (period 2).

Source files
------------

// File: rtl/multi_phase_clk_div_pkg.sv
// Shared definitions for the multi-phase clock divider.
//   ch_state_t     : per-channel FSM state (IDLE, DELAY, RUN)
//   DEF_HALF_DFLT  : default half-period in clk50m cycles (50 kHz output)
//   HALF_FN_W      : width of the half_nz() argument/result; CW must not exceed it
//   half_nz()      : maps a half-period of 0 to 1 so a channel always advances
package multi_phase_clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RUN   = 2'd2
  } ch_state_t;

  localparam int DEF_HALF_DFLT = 500;
  localparam int HALF_FN_W     = 64;

  function automatic logic [HALF_FN_W-1:0] half_nz(input logic [HALF_FN_W-1:0] h);
    return (h == '0) ? HALF_FN_W'(1) : h;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: FSM, counter, active/shadow half-period and pending flag.
// Ports:
//   clk50m, rst         : system clock, async active-high reset
//   en                  : channel enable (0 forces IDLE next edge)
//   sync                : global restart pulse, ignored while IDLE
//   wr                  : accepted config write targeting this channel
//   wr_half, wr_delay   : config data for that write
//   clk_out             : divided clock (registered)
//   tick                : one-cycle pulse on every clk_out toggle
//   running             : state is not IDLE
//   pending             : a half-period change waits for the next boundary
module clk_div_channel
  import multi_phase_clk_div_pkg::*;
#(
  parameter int CW       = 30,
  parameter int DEF_HALF = DEF_HALF_DFLT
) (
  input  logic          clk50m,
  input  logic          rst,
  input  logic          en,
  input  logic          sync,
  input  logic          wr,
  input  logic [CW-1:0] wr_half,
  input  logic [CW-1:0] wr_delay,
  output logic          clk_out,
  output logic          tick,
  output logic          running,
  output logic          pending
);

  ch_state_t     state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] half;
  logic [CW-1:0] shadow;
  logic [CW-1:0] delay;
  logic [CW-1:0] dly_act;
  logic [CW-1:0] wr_half_nz;
  logic          starting;

  assign wr_half_nz = CW'(half_nz(HALF_FN_W'(wr_half)));
  assign running    = (state != ST_IDLE);
  // A channel leaving IDLE this edge is treated as busy for config purposes,
  // so a half written on that edge waits for the first period boundary.
  assign starting   = (state == ST_IDLE) && en;

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      half    <= CW'(DEF_HALF);
      shadow  <= CW'(DEF_HALF);
      delay   <= '0;
      dly_act <= '0;
      pending <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (!en) begin
        state   <= ST_IDLE;
        cnt     <= '0;
        clk_out <= 1'b0;
        if (pending) begin
          half    <= shadow;
          pending <= 1'b0;
        end
      end else if (sync && state != ST_IDLE) begin
        // Phase realign: restart exactly like a fresh enable.
        state   <= (delay == '0) ? ST_RUN : ST_DELAY;
        dly_act <= delay;
        cnt     <= '0;
        clk_out <= 1'b0;
        if (pending) begin
          half    <= shadow;
          pending <= 1'b0;
        end
      end else begin
        unique case (state)
          ST_IDLE: begin
            state   <= (delay == '0) ? ST_RUN : ST_DELAY;
            dly_act <= delay;
            cnt     <= '0;
          end
          ST_DELAY: begin
            // dly_act is latched at start so a delay write mid-DELAY only
            // affects the next start.
            if (cnt == dly_act - CW'(1)) begin
              state <= ST_RUN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          ST_RUN: begin
            if (cnt == half - CW'(1)) begin
              clk_out <= ~clk_out;
              tick    <= 1'b1;
              cnt     <= '0;
              if (pending) begin
                half    <= shadow;
                pending <= 1'b0;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end

      // A write is only accepted while pending is clear, so it never collides
      // with the pending-apply paths above.
      if (wr) begin
        delay <= wr_delay;
        if (state == ST_IDLE && !starting) begin
          half <= wr_half_nz;
        end else begin
          shadow  <= wr_half_nz;
          pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/multi_phase_clk_div.sv
// Multi-channel clock divider from the 50 MHz system clock. Each channel
// generates a square wave with programmable half-period and start delay.
// Ports:
//   clk50m, rst              : system clock, async active-high reset
//   en[NCH]                  : per-channel enable
//   sync                     : global phase-realign pulse
//   cfg_valid / cfg_ready    : config write handshake (ready is combinational on cfg_ch)
//   cfg_ch, cfg_half, cfg_delay : target channel and config data
//   clk_out[NCH], tick[NCH], running[NCH] : per-channel outputs
module multi_phase_clk_div
  import multi_phase_clk_div_pkg::*;
#(
  parameter  int NCH      = 4,
  parameter  int CW       = 30,
  parameter  int DEF_HALF = DEF_HALF_DFLT,
  localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk50m,
  input  logic           rst,
  input  logic [NCH-1:0] en,
  input  logic           sync,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_half,
  input  logic [CW-1:0]  cfg_delay,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] running
);

  logic [NCH-1:0]      pending;
  logic [NCH-1:0]      wr_sel;
  // Pending flags padded to the full cfg_ch range; unused codes read as not
  // pending, so writes to nonexistent channels are accepted and dropped.
  logic [2**CHW-1:0]   pend_pad;

  always_comb begin
    pend_pad          = '0;
    pend_pad[NCH-1:0] = pending;
  end

  assign cfg_ready = !pend_pad[cfg_ch];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign wr_sel[i] = cfg_valid && cfg_ready && (cfg_ch == CHW'(i));

    clk_div_channel #(
      .CW       (CW),
      .DEF_HALF (DEF_HALF)
    ) u_ch (
      .clk50m   (clk50m),
      .rst      (rst),
      .en       (en[i]),
      .sync     (sync),
      .wr       (wr_sel[i]),
      .wr_half  (cfg_half),
      .wr_delay (cfg_delay),
      .clk_out  (clk_out[i]),
      .tick     (tick[i]),
      .running  (running[i]),
      .pending  (pending[i])
    );
  end

endmodule
